// File: rtl/ped_request_conditioner.sv
// rtl/ped_request_conditioner.sv - sync/debounce of pedestrian and emergency inputs, held ped request FSM
module ped_request_conditioner #(
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter int COOLDOWN_CYCLES  = 16,
  parameter int EMER_HOLD_CYCLES = 8,
  parameter int CNT_W            = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ped_btn_raw,
  input  logic             emergency_raw,
  input  logic             walk,
  output logic             ped_btn,
  output logic             emergency,
  output logic             wait_lamp,
  output logic [CNT_W-1:0] press_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CW = $clog2(COOLDOWN_CYCLES + 1);
  localparam int HW = $clog2(EMER_HOLD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, PENDING, SERVING, COOLDOWN} state_t;

  logic          btn_s1, btn_s2, emer_s1, emer_s2;
  logic          deb_btn, deb_btn_q, deb_emer;
  logic [DW-1:0] btn_cnt, emer_cnt;
  logic [HW-1:0] hold;
  logic [CW-1:0] cool_cnt;
  logic          deferred;
  state_t        state;
  logic          press, accept, emer_fall_now;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_s1  <= 1'b0;
      btn_s2  <= 1'b0;
      emer_s1 <= 1'b0;
      emer_s2 <= 1'b0;
    end else begin
      btn_s1  <= ped_btn_raw;
      btn_s2  <= btn_s1;
      emer_s1 <= emergency_raw;
      emer_s2 <= emer_s1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_btn   <= 1'b0;
      deb_btn_q <= 1'b0;
      btn_cnt   <= '0;
    end else begin
      deb_btn_q <= deb_btn;
      if (btn_s2 == deb_btn) begin
        btn_cnt <= '0;
      end else if (btn_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        deb_btn <= ~deb_btn;
        btn_cnt <= '0;
      end else begin
        btn_cnt <= btn_cnt + DW'(1);
      end
    end
  end

  // Hold loads on the same edge deb_emer drops, so the stretch needs no extra cycle.
  assign emer_fall_now = deb_emer && !emer_s2 && (emer_cnt == DW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_emer  <= 1'b0;
      emer_cnt  <= '0;
      hold      <= '0;
      emergency <= 1'b0;
    end else begin
      if (emer_s2 == deb_emer) begin
        emer_cnt <= '0;
      end else if (emer_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        deb_emer <= ~deb_emer;
        emer_cnt <= '0;
      end else begin
        emer_cnt <= emer_cnt + DW'(1);
      end
      if (emer_fall_now)
        hold <= HW'(EMER_HOLD_CYCLES);
      else if (hold != '0)
        hold <= hold - HW'(1);
      emergency <= deb_emer | (hold != '0);
    end
  end

  assign press  = deb_btn & ~deb_btn_q;
  assign accept = press & (((state == IDLE) & ~walk) | ((state == COOLDOWN) & ~deferred));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      press_count <= '0;
    else if (accept && (press_count != {CNT_W{1'b1}}))
      press_count <= press_count + CNT_W'(1);
  end

  // While emergency is high only press capture proceeds; walk and the cooldown timer are frozen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cool_cnt <= '0;
      deferred <= 1'b0;
      ped_btn  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (press && !walk) begin
            state   <= PENDING;
            ped_btn <= 1'b1;
          end
        end
        PENDING: begin
          if (walk && !emergency) begin
            state   <= SERVING;
            ped_btn <= 1'b0;
          end
        end
        SERVING: begin
          if (!walk && !emergency) begin
            state    <= COOLDOWN;
            cool_cnt <= CW'(COOLDOWN_CYCLES);
          end
        end
        COOLDOWN: begin
          if (emergency) begin
            if (press) deferred <= 1'b1;
          end else if (cool_cnt == CW'(1)) begin
            deferred <= 1'b0;
            if (deferred || press) begin
              state   <= PENDING;
              ped_btn <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            cool_cnt <= cool_cnt - CW'(1);
            if (press) deferred <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wait_lamp = ped_btn;

endmodule

// File: tb/tb_ped_request_conditioner.sv
// tb/tb_ped_request_conditioner.sv - directed self-checking bench for ped_request_conditioner
module tb_ped_request_conditioner;

  logic       clk;
  logic       reset;
  logic       ped_btn_raw;
  logic       emergency_raw;
  logic       walk;
  logic       ped_btn;
  logic       emergency;
  logic       wait_lamp;
  logic [7:0] press_count;

  int n_tests = 0;
  int n_fail  = 0;
  int bad     = 0;

  ped_request_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .COOLDOWN_CYCLES(16),
    .EMER_HOLD_CYCLES(8),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ped_btn_raw(ped_btn_raw),
    .emergency_raw(emergency_raw),
    .walk(walk),
    .ped_btn(ped_btn),
    .emergency(emergency),
    .wait_lamp(wait_lamp),
    .press_count(press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Walk phase served then cooldown allowed to expire back to IDLE.
  task automatic serve();
    walk = 1'b1;
    tick(1);
    walk = 1'b0;
    tick(1);
    tick(18);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    ped_btn_raw = 1'b0;
    emergency_raw = 1'b0;
    walk = 1'b0;
    #1;
    check("rst_ped_btn", ped_btn, 0);
    check("rst_emergency", emergency, 0);
    check("rst_wait_lamp", wait_lamp, 0);
    check("rst_count", press_count, 0);
    tick(2);
    reset = 1'b1;

    // clean press
    ped_btn_raw = 1'b1;
    tick(6);
    check("t1_before_edge7", ped_btn, 0);
    tick(1);
    check("t1_ped_btn", ped_btn, 1);
    check("t1_wait_lamp", wait_lamp, 1);
    check("t1_count", press_count, 1);
    tick(3);
    ped_btn_raw = 1'b0;
    check("t1_held", ped_btn, 1);
    walk = 1'b1;
    tick(1);
    check("t1_served", ped_btn, 0);
    tick(10);

    // cooldown deferral
    walk = 1'b0;
    tick(1);
    ped_btn_raw = 1'b1;
    tick(15);
    check("t3_deferred", ped_btn, 0);
    check("t3_count_deferred", press_count, 2);
    tick(1);
    check("t3_expiry", ped_btn, 1);
    check("t3_count", press_count, 2);
    ped_btn_raw = 1'b0;
    serve();
    check("t3_idle", ped_btn, 0);

    // bounce rejection
    ped_btn_raw = 1'b1; tick(3);
    ped_btn_raw = 1'b0; tick(3);
    ped_btn_raw = 1'b1; tick(2);
    ped_btn_raw = 1'b0; tick(12);
    check("t2_ped_btn", ped_btn, 0);
    check("t2_count", press_count, 2);

    // press while walk already active
    walk = 1'b1;
    ped_btn_raw = 1'b1;
    tick(10);
    check("pw_ped_btn", ped_btn, 0);
    check("pw_count", press_count, 2);
    walk = 1'b0;
    tick(2);
    check("pw_after_walk", ped_btn, 0);
    ped_btn_raw = 1'b0;
    tick(8);

    // emergency stretch and FSM freeze
    ped_btn_raw = 1'b1;
    tick(7);
    check("t4_pending", ped_btn, 1);
    check("t4_count", press_count, 3);
    ped_btn_raw = 1'b0;
    tick(8);
    emergency_raw = 1'b1;
    tick(6);
    check("t4_emer_before", emergency, 0);
    tick(1);
    check("t4_emer_on", emergency, 1);
    walk = 1'b1;
    tick(3);
    check("t4_frozen", ped_btn, 1);
    walk = 1'b0;
    tick(10);
    emergency_raw = 1'b0;
    tick(14);
    check("t4_emer_hold", emergency, 1);
    tick(1);
    check("t4_emer_off", emergency, 0);
    check("t4_still_pending", ped_btn, 1);
    walk = 1'b1;
    tick(1);
    check("t4_served", ped_btn, 0);
    walk = 1'b0;
    tick(1);
    tick(18);

    // async reset in PENDING
    ped_btn_raw = 1'b1;
    tick(7);
    check("t5_pending", ped_btn, 1);
    check("t5_count_pre", press_count, 4);
    #3;
    reset = 1'b0;
    #1;
    check("t5_rst_ped_btn", ped_btn, 0);
    check("t5_rst_wait_lamp", wait_lamp, 0);
    check("t5_rst_count", press_count, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick(6);
    check("t5_before_edge7", ped_btn, 0);
    tick(1);
    check("t5_ped_btn", ped_btn, 1);
    check("t5_count", press_count, 1);

    // saturation
    ped_btn_raw = 1'b0;
    serve();
    for (int i = 0; i < 259; i++) begin
      ped_btn_raw = 1'b1;
      tick(7);
      if (ped_btn !== 1'b1) bad++;
      ped_btn_raw = 1'b0;
      serve();
      if (i == 253) check("t6_reach_max", press_count, 255);
    end
    check("t6_requests", bad, 0);
    check("t6_saturated", press_count, 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
